// File: rtl/basys3_user_input.sv
// Input conditioning for the Basys3 push buttons and slide switches.
// Each channel is synchronized into clk_ext, debounced, and given registered change pulses.

module basys3_user_input #(
   parameter int unsigned NUM_BTN         = 5,
   parameter int unsigned NUM_SW          = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic               clk_ext,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_async,
   input  logic [NUM_SW-1:0]  sw_async,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_SW-1:0]  sw_level,
   output logic [NUM_SW-1:0]  sw_change
);

   localparam int unsigned NUM_CH = NUM_BTN + NUM_SW;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   // Buttons occupy the low channel indices, switches the high ones.
   logic [NUM_CH-1:0] raw;
   (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] meta;
   logic [NUM_CH-1:0] sync;
   logic [NUM_CH-1:0] level;

   assign raw = {sw_async, btn_async};

   always_ff @(posedge clk_ext) begin
      if (rst) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : gen_ch
      logic [CNT_WIDTH-1:0] cnt_q;
      logic [CNT_WIDTH-1:0] cnt_d;
      logic                 level_q;
      logic                 accept;

      // Any return to the accepted level drops the count, so bounces restart the window.
      always_comb begin
         accept = 1'b0;
         cnt_d  = '0;
         if (sync[ch] != level_q) begin
            if (cnt_q == CNT_MAX) begin
               accept = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk_ext) begin
         if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            if (accept) begin
               level_q <= sync[ch];
            end
         end
      end

      assign level[ch] = level_q;

      if (ch < NUM_BTN) begin : gen_btn_pulse
         logic press_q;
         logic release_q;

         always_ff @(posedge clk_ext) begin
            if (rst) begin
               press_q   <= 1'b0;
               release_q <= 1'b0;
            end else begin
               press_q   <= accept & sync[ch];
               release_q <= accept & ~sync[ch];
            end
         end

         assign btn_press[ch]   = press_q;
         assign btn_release[ch] = release_q;
      end else begin : gen_sw_pulse
         logic change_q;

         always_ff @(posedge clk_ext) begin
            if (rst) begin
               change_q <= 1'b0;
            end else begin
               change_q <= accept;
            end
         end

         assign sw_change[ch-NUM_BTN] = change_q;
      end
   end

   assign btn_level = level[NUM_BTN-1:0];
   assign sw_level  = level[NUM_CH-1:NUM_BTN];

endmodule

// File: tb/tb_basys3_user_input.sv
// Bench for basys3_user_input: directed scenarios with literal checks plus random stimulus,
// all outputs compared every cycle against a sliding-window reference model.

module tb_basys3_user_input;

   localparam int NB  = 5;
   localparam int NS  = 16;
   localparam int NC  = NB + NS;
   localparam int DEB = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn_async;
   logic [NS-1:0] sw_async;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic [NS-1:0] sw_level;
   logic [NS-1:0] sw_change;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   basys3_user_input #(
      .NUM_BTN        (NB),
      .NUM_SW         (NS),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk_ext    (clk),
      .rst        (rst),
      .btn_async  (btn_async),
      .sw_async   (sw_async),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .sw_level   (sw_level),
      .sw_change  (sw_change)
   );

   // Reference: a value reaches the debouncer two edges after it is sampled; the level flips
   // once the last DEB values seen since the previous flip (or reset) all disagree with it.
   logic [NC-1:0] pad_d1, pad_d2, seen;
   logic [NC-1:0] m_level, m_rise, m_fall;
   bit            win [NC][$];

   initial begin
      forever begin
         @(posedge clk);
         m_rise = '0;
         m_fall = '0;
         if (rst) begin
            pad_d1  = '0;
            pad_d2  = '0;
            m_level = '0;
            for (int c = 0; c < NC; c++) win[c].delete();
         end else begin
            seen   = pad_d2;
            pad_d2 = pad_d1;
            pad_d1 = {sw_async, btn_async};
            for (int c = 0; c < NC; c++) begin
               bit all_diff;
               win[c].push_back(seen[c]);
               if (win[c].size() > DEB) void'(win[c].pop_front());
               all_diff = (win[c].size() == DEB);
               for (int k = 0; k < win[c].size(); k++) begin
                  if (win[c][k] == m_level[c]) all_diff = 1'b0;
               end
               if (all_diff) begin
                  m_level[c] = ~m_level[c];
                  m_rise[c]  = m_level[c];
                  m_fall[c]  = ~m_level[c];
                  win[c].delete();
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         vectors++;
         if (btn_level !== m_level[NB-1:0] || btn_press !== m_rise[NB-1:0] ||
             btn_release !== m_fall[NB-1:0] || sw_level !== m_level[NC-1:NB] ||
             sw_change !== (m_rise[NC-1:NB] | m_fall[NC-1:NB])) begin
            miscompares++;
            $display("FAIL model t=%0t: got lvl=%h/%h prs=%h rel=%h chg=%h, required lvl=%h/%h prs=%h rel=%h chg=%h",
                     $time, btn_level, sw_level, btn_press, btn_release, sw_change,
                     m_level[NB-1:0], m_level[NC-1:NB], m_rise[NB-1:0], m_fall[NB-1:0],
                     m_rise[NC-1:NB] | m_fall[NC-1:NB]);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   initial begin
      logic [NB-1:0] bmask;
      logic [NS-1:0] smask;

      // Reset with every input held high.
      rst       = 1'b1;
      btn_async = '1;
      sw_async  = '1;
      tick(4);
      check("rst_btn_level", 32'(btn_level), 32'h0);
      check("rst_sw_level", 32'(sw_level), 32'h0);
      check("rst_pulses", 32'({btn_press, btn_release, sw_change}), 32'h0);
      rst = 1'b0;
      tick(9);
      check("post_rst_early", 32'(btn_level), 32'h0);
      tick(1);
      check("post_rst_btn_level", 32'(btn_level), 32'h1F);
      check("post_rst_sw_level", 32'(sw_level), 32'hFFFF);
      check("post_rst_press", 32'(btn_press), 32'h1F);
      check("post_rst_change", 32'(sw_change), 32'hFFFF);
      tick(1);
      check("post_rst_pulse_end", 32'({btn_press, sw_change}), 32'h0);

      btn_async = '0;
      sw_async  = '0;
      tick(14);
      check("settle_low", 32'({btn_level, sw_level}), 32'h0);

      // Clean press and release on button 2.
      btn_async = 5'b00100;
      tick(9);
      check("press_early", 32'(btn_level), 32'h0);
      tick(1);
      check("press_level", 32'(btn_level), 32'h04);
      check("press_pulse", 32'(btn_press), 32'h04);
      tick(10);
      btn_async = '0;
      tick(9);
      check("release_early", 32'(btn_level), 32'h04);
      tick(1);
      check("release_pulse", 32'(btn_release), 32'h04);
      check("release_level", 32'(btn_level), 32'h0);
      tick(5);

      // Bounces on button 0 restart the stability window.
      btn_async[0] = 1'b1; tick(5);
      btn_async[0] = 1'b0; tick(2);
      btn_async[0] = 1'b1; tick(7);
      btn_async[0] = 1'b0; tick(1);
      btn_async[0] = 1'b1;
      tick(9);
      check("bounce_early", 32'({btn_level, btn_press}), 32'h0);
      tick(1);
      check("bounce_press", 32'(btn_press), 32'h01);
      btn_async = '0;
      tick(15);

      // Threshold: 7 high cycles rejected, 8 accepted.
      sw_async = 16'h8000; tick(7);
      sw_async = '0;       tick(15);
      check("thresh_7", 32'(sw_level), 32'h0);
      sw_async = 16'h8000; tick(8);
      sw_async = '0;       tick(2);
      check("thresh_8_level", 32'(sw_level), 32'h8000);
      check("thresh_8_change", 32'(sw_change), 32'h8000);
      tick(15);

      // Many switches accepting on the same edge.
      sw_async = 16'hA5A5;
      tick(9);
      check("simul_early", 32'(sw_change), 32'h0);
      tick(1);
      check("simul_change", 32'(sw_change), 32'hA5A5);
      check("simul_level", 32'(sw_level), 32'hA5A5);
      tick(1);
      check("simul_pulse_end", 32'(sw_change), 32'h0);

      // Reset five cycles into a pending press on button 4.
      btn_async = 5'h10;
      tick(7);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(9);
      check("midrst_early", 32'(btn_press), 32'h0);
      tick(1);
      check("midrst_press", 32'(btn_press), 32'h10);
      check("midrst_level", 32'(btn_level), 32'h10);

      // Random toggling with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         for (int b = 0; b < NB; b++) bmask[b] = ($urandom_range(0, 9) == 0);
         for (int s = 0; s < NS; s++) smask[s] = ($urandom_range(0, 9) == 0);
         btn_async = btn_async ^ bmask;
         sw_async  = sw_async ^ smask;
         rst       = ($urandom_range(0, 599) == 0);
         tick(1);
      end
      rst = 1'b0;
      tick(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/basys3_user_input.md
# basys3_user_input

Input-side conditioning for the Basys3 user controls: five push buttons and sixteen slide switches. It takes the asynchronous board inputs after the pad input buffers and brings them into the `clk_ext` domain with two-flop synchronizers. It then debounces each input with a per-channel stability counter and produces clean levels plus single-cycle change pulses for the rest of the design. It is the input counterpart of the board I/O layer that drives the LEDs and VGA pins.

## Interface
- `NUM_BTN`, 5: number of push-button channels (U, L, R, D, C on the board).
- `NUM_SW`, 16: number of slide-switch channels.
- `DEBOUNCE_CYCLES`, 1000000: clock cycles an input must be stable before its level is accepted (10 ms at 100 MHz). Must be ≥ 2.
- `CNT_WIDTH`, `$clog2(DEBOUNCE_CYCLES)`: debounce counter width. Derived; not overridden.

Ports:
- `clk_ext`, input, 1: system clock from the global clock buffer.
- `rst`, input, 1: reset, synchronous, active-high.
- `btn_async`, input, `NUM_BTN`: raw button inputs, asynchronous to `clk_ext`, active-high.
- `sw_async`, input, `NUM_SW`: raw switch inputs, asynchronous to `clk_ext`.
- `btn_level`, output, `NUM_BTN`: debounced button state.
- `btn_press`, output, `NUM_BTN`: one-cycle pulse on each accepted 0→1 button transition.
- `btn_release`, output, `NUM_BTN`: one-cycle pulse on each accepted 1→0 button transition.
- `sw_level`, output, `NUM_SW`: debounced switch state.
- `sw_change`, output, `NUM_SW`: one-cycle pulse on each accepted switch transition, in either direction.

## Operation
- Every button and switch channel is an identical, independent instance. There is no cross-channel interaction.
- **Synchronizer:** two flops in series, `meta` then `sync`. The first flop carries the `ASYNC_REG` attribute. Both flops reset to 0.
- **Debouncer:** each channel holds `level` (1 bit) and `cnt` (`CNT_WIDTH` bits).
  - **IDLE** (`sync == level`): `cnt` <= 0.
  - **PENDING** (`sync != level`, `cnt < DEBOUNCE_CYCLES-1`): `cnt` <= `cnt + 1`.
  - **ACCEPT** (`sync != level`, `cnt == DEBOUNCE_CYCLES-1`): `level` <= `sync`, `cnt` <= 0, and the channel's pulse output is asserted for the next cycle.
- A glitch back to the old level while PENDING returns the channel to IDLE and discards the count. Bounces therefore restart the stability window.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- **Pulses:** registered outputs, asserted in the same cycle the new `level` first appears at the output.
  - `btn_press` = `level` rose.
  - `btn_release` = `level` fell.
  - `sw_change` = `level` changed.
  - A pulse never lasts more than one cycle. Two pulses on the same channel are at least `DEBOUNCE_CYCLES` cycles apart.
- **Reset:** while `rst` = 1 on a clock edge, every `meta`, `sync`, `level`, `cnt` and pulse register is cleared. The reset value of every output is 0.
- **Reset mid-operation:** a PENDING count is discarded.
- **After reset:** an input held at 1 through reset is debounced normally after `rst` deasserts. It then produces a `btn_press` or `sw_change` pulse. This is intended behaviour, and downstream logic must tolerate it.
- **Simultaneous events:** any number of channels may accept on the same edge, and each pulses independently.

## Timing
- Latency from the first `clk_ext` edge that samples a new, stable pad value to the new `level` and pulse: exactly `DEBOUNCE_CYCLES + 2` cycles.
  - The first 2 cycles are the synchronizer.
  - The remaining `DEBOUNCE_CYCLES` cycles are spent in PENDING up to and including ACCEPT.
- An input pulse shorter than `DEBOUNCE_CYCLES` cycles after synchronization produces no output change.
- An input pulse of exactly `DEBOUNCE_CYCLES` cycles after synchronization is accepted.
- All outputs are registered. There is no combinational path from any input to any output.
- Single clock domain (`clk_ext`). The only asynchronous crossing is at the synchronizer's first flop.

## Test plan
Use `DEBOUNCE_CYCLES = 8` for simulation.
1. **Reset values:** hold `rst` = 1 for 4 cycles with all inputs at 1 → all outputs 0 throughout. After release, `btn_level` = 5'h1F and `sw_level` = 16'hFFFF exactly 10 cycles after the first sampling edge. Each `btn_press` and `sw_change` bit pulses once for 1 cycle.
2. **Clean press and release:** raise `btn_async[2]` and hold it for 20 cycles → `btn_level[2]` = 1 and a `btn_press[2]` pulse 10 cycles later. Drop it → `btn_release[2]` pulses 10 cycles later. No other bit changes.
3. **Bounce rejection:** toggle `btn_async[0]` as 1 for 5 cycles, 0 for 2, 1 for 7, 0 for 1, then 1 steady → exactly one `btn_press[0]`, 10 cycles after the start of the final steady high.
4. **Threshold boundary:** a high pulse of 7 cycles on `sw_async[15]` → no change. A high pulse of 8 cycles → `sw_level[15]` goes to 1 and `sw_change[15]` pulses once.
5. **Simultaneous channels:** `sw_async` 16'h0000 → 16'hA5A5 on one edge → `sw_change` = 16'hA5A5 for exactly 1 cycle, with `sw_level` = 16'hA5A5 in the same cycle.
6. **Mid-operation reset:** assert `rst` for 1 cycle while `btn_async[4]` is 5 cycles into PENDING → the count restarts. `btn_press[4]` pulses 10 cycles after the reset-release edge, not earlier.
